// File: rtl/a_ctrl_pkg.sv
// Shared opcodes, ALU mode codes, FSM state encoding and the decoder result
// record for the multi-cycle control unit.
package a_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [1:0] ALU_FUNCT = 2'd0;
    localparam logic [1:0] ALU_ADD   = 2'd1;
    localparam logic [1:0] ALU_AND   = 2'd2;
    localparam logic [1:0] ALU_OR    = 2'd3;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef struct packed {
        logic       legal;
        logic       is_load;
        logic       is_store;
        logic [1:0] alu_mode;
        logic       imm_sel;
        logic       bank_we;
    } dec_t;

endpackage

// File: rtl/a_multicycle_control_dec.sv
// Pure combinational opcode decoder; the FSM decides in which state each
// decoded field is allowed to reach the datapath.
module a_op_decoder
    import a_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] op_i,
    output dec_t            dec_o
);

    always_comb begin
        dec_o = '0;
        if (op_i == OP_W'(OP_RTYPE)) begin
            dec_o.legal    = 1'b1;
            dec_o.alu_mode = ALU_FUNCT;
            dec_o.bank_we  = 1'b1;
        end else if (op_i == OP_W'(OP_LW)) begin
            dec_o.legal    = 1'b1;
            dec_o.is_load  = 1'b1;
            dec_o.alu_mode = ALU_ADD;
            dec_o.imm_sel  = 1'b1;
            dec_o.bank_we  = 1'b1;
        end else if (op_i == OP_W'(OP_SW)) begin
            dec_o.legal    = 1'b1;
            dec_o.is_store = 1'b1;
            dec_o.alu_mode = ALU_ADD;
            dec_o.imm_sel  = 1'b1;
        end else if (op_i == OP_W'(OP_ADDI)) begin
            dec_o.legal    = 1'b1;
            dec_o.alu_mode = ALU_ADD;
            dec_o.imm_sel  = 1'b1;
            dec_o.bank_we  = 1'b1;
        end else if (op_i == OP_W'(OP_ANDI)) begin
            dec_o.legal    = 1'b1;
            dec_o.alu_mode = ALU_AND;
            dec_o.imm_sel  = 1'b1;
            dec_o.bank_we  = 1'b1;
        end else if (op_i == OP_W'(OP_ORI)) begin
            dec_o.legal    = 1'b1;
            dec_o.alu_mode = ALU_OR;
            dec_o.imm_sel  = 1'b1;
            dec_o.bank_we  = 1'b1;
        end
    end

endmodule

// File: rtl/a_multicycle_control.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with a memory
// acknowledge timeout, illegal-opcode detection and retired/error counters.
// Handshake: an opcode transfers on a rising edge where ins_valid && ins_ready;
// ins_ready is high only in FETCH and ins_valid may be held across instructions.
module a_multicycle_control
    import a_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 2,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    oper_in,
    input  logic               ins_valid,
    output logic               ins_ready,
    input  logic               mem_ack,
    output logic               w_e_banco,
    output logic               w_e_memo,
    output logic               r_e_memo,
    output logic [ALUOP_W-1:0] habilitador,
    output logic               signal_MUX_F,
    output logic               MUX_INS,
    output logic               MUX_D_A,
    output logic               busy,
    output logic               illegal_op,
    output logic               mem_timeout,
    output logic [CNT_W-1:0]   retired,
    output logic [CNT_W-1:0]   err_count,
    output state_t             state_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic [CNT_W-1:0] retired_q, err_q;
    logic             retire_inc, err_inc, ready_c;
    dec_t             dec;

    a_op_decoder #(.OP_W(OP_W)) u_dec (
        .op_i  (op_q),
        .dec_o (dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            tcnt_q    <= '0;
            retired_q <= '0;
            err_q     <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tcnt_q  <= tcnt_d;
            if (retire_inc) retired_q <= retired_q + 1'b1;
            if (err_inc && err_q != '1) err_q <= err_q + 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        tcnt_d       = tcnt_q;
        retire_inc   = 1'b0;
        err_inc      = 1'b0;
        ready_c      = 1'b0;
        w_e_banco    = 1'b0;
        w_e_memo     = 1'b0;
        r_e_memo     = 1'b0;
        habilitador  = '0;
        signal_MUX_F = 1'b0;
        MUX_INS      = 1'b0;
        MUX_D_A      = 1'b0;
        illegal_op   = 1'b0;
        mem_timeout  = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                ready_c = 1'b1;
                if (ins_valid) begin
                    op_d    = oper_in;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec.legal) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_op = 1'b1;
                    err_inc    = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXEC: begin
                habilitador = ALUOP_W'(dec.alu_mode);
                MUX_INS     = dec.imm_sel;
                MUX_D_A     = dec.is_store;
                state_d     = (dec.is_load || dec.is_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                habilitador = ALUOP_W'(dec.alu_mode);
                MUX_INS     = dec.imm_sel;
                MUX_D_A     = dec.is_store;
                r_e_memo    = dec.is_load;
                w_e_memo    = dec.is_store;
                tcnt_d      = tcnt_q + 1'b1;
                // An ack in the last allowed cycle still wins over the timeout.
                if (mem_ack) begin
                    tcnt_d = '0;
                    if (dec.is_load) begin
                        state_d = S_WB;
                    end else begin
                        retire_inc = 1'b1;
                        state_d    = S_FETCH;
                    end
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    tcnt_d      = '0;
                    mem_timeout = 1'b1;
                    err_inc     = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_WB: begin
                w_e_banco    = dec.bank_we;
                signal_MUX_F = dec.is_load;
                retire_inc   = 1'b1;
                state_d      = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign ins_ready = ready_c & rst_n;
    assign busy      = (state_q != S_FETCH);
    assign retired   = retired_q;
    assign err_count = err_q;
    assign state_o   = state_q;

endmodule
